// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between writeback and a buffered MDU result path.
// Optional WBARB_BYPASS_EN writes an MDU result straight through when the port and FIFO are idle.
module wb_port_arbiter #(
    parameter int XLEN = 32,
    parameter int DEPTH = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       RegWriteW,
    input  logic [4:0]                 RdW,
    input  logic [XLEN-1:0]            ResultW,
    input  logic                       mdu_valid,
    output logic                       mdu_ready,
    input  logic [4:0]                 mdu_rd,
    input  logic [XLEN-1:0]            mdu_data,
    output logic                       stall_req,
    output logic                       rf_we,
    output logic [4:0]                 rf_rd,
    output logic [XLEN-1:0]            rf_wdata,
    output logic                       grant_mdu,
    output logic [$clog2(DEPTH):0]     pending_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      rdMem [DEPTH];
    logic [XLEN-1:0] dataMem [DEPTH];
    logic [AW-1:0]   rdPtr, wrPtr;
    logic [CW-1:0]   count;
    logic [3:0]      waitCnt;
    logic            starve;
    logic            empty, full, wbWrite, forceDrain, bypass, pop, push, starveNext;

    always_comb begin
        empty = count == '0;
        full = count == CW'(DEPTH);
        wbWrite = !reset && RegWriteW && RdW != 5'd0;
        forceDrain = !reset && starve && !empty;
`ifdef WBARB_BYPASS_EN
        bypass = !reset && empty && !wbWrite && !starve && mdu_valid && mdu_rd != 5'd0;
`else
        bypass = 1'b0;
`endif
        // a forced drain overrides writeback; the hazard unit replays the W-stage write
        pop = !reset && !empty && (forceDrain || !wbWrite);
        mdu_ready = !reset && (!full || bypass);
        push = mdu_valid && mdu_ready && mdu_rd != 5'd0 && !bypass;
        stall_req = forceDrain;
        grant_mdu = pop || bypass;
        rf_we = grant_mdu || wbWrite;
        rf_rd = pop ? rdMem[rdPtr] : wbWrite ? RdW : bypass ? mdu_rd : 5'd0;
        rf_wdata = pop ? dataMem[rdPtr] : wbWrite ? ResultW : bypass ? mdu_data : '0;
        pending_cnt = count;
        starveNext = !pop && !empty && (starve || int'(waitCnt) + 1 >= STARVE_LIMIT - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            waitCnt <= '0;
            starve <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            waitCnt <= (pop || empty) ? '0 : (waitCnt == 4'hF ? waitCnt : waitCnt + 4'd1);
            starve <= starveNext;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rdMem[wrPtr] <= mdu_rd;
            dataMem[wrPtr] <= mdu_data;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: table-driven cycle vectors plus a hand-written starvation sequence.
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        RegWriteW = 1'b0;
    logic [4:0]  RdW = '0;
    logic [31:0] ResultW = '0;
    logic        mdu_valid = 1'b0;
    logic        mdu_ready;
    logic [4:0]  mdu_rd = '0;
    logic [31:0] mdu_data = '0;
    logic        stall_req, rf_we, grant_mdu;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [1:0]  pending_cnt;

    int errors = 0;
    int checks = 0;

    wb_port_arbiter #(.XLEN(32), .DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .stall_req(stall_req), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .grant_mdu(grant_mdu), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, we;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        eWe;
        logic [4:0]  eRd;
        logic [31:0] eData;
        logic        eGnt, eStall, eRdy;
        logic [1:0]  ePend;
        logic        chkPend;
    } vecT;

    vecT vecs[$];

    task automatic add(input logic rst, we, input logic [4:0] rd, input logic [31:0] res,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic eWe, input logic [4:0] eRd, input logic [31:0] eData,
                       input logic eGnt, eStall, eRdy, input logic [1:0] ePend, input logic chkPend);
        vecT v;
        v.rst = rst; v.we = we; v.rd = rd; v.res = res; v.mv = mv; v.mrd = mrd; v.md = md;
        v.eWe = eWe; v.eRd = eRd; v.eData = eData; v.eGnt = eGnt; v.eStall = eStall;
        v.eRdy = eRdy; v.ePend = ePend; v.chkPend = chkPend;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        // rst we rd res | mv mrd md | eWe eRd eData eGnt eStall eRdy ePend chk
        add(1, 1, 5, 32'hAA, 1, 7, 32'h1234,  0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 5, 32'hAA, 1, 7, 32'h1234,  0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 5, 32'hAA, 1, 7, 32'h1234,  1, 5, 32'hAA, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0,      0, 0, 0,         1, 7, 32'h1234, 1, 0, 1, 1, 1);
        add(0, 0, 0, 0,      0, 0, 0,         0, 0, 0, 0, 0, 1, 0, 1);
        // starvation with one buffered result
        add(0, 1, 3, 32'h33, 1, 10, 32'hA0,   1, 3, 32'h33, 0, 0, 1, 0, 1);
        add(0, 1, 3, 32'h33, 0, 0, 0,         1, 3, 32'h33, 0, 0, 1, 1, 1);
        add(0, 1, 3, 32'h33, 0, 0, 0,         1, 3, 32'h33, 0, 0, 1, 1, 1);
        add(0, 1, 3, 32'h33, 0, 0, 0,         1, 3, 32'h33, 0, 0, 1, 1, 1);
        add(0, 1, 3, 32'h33, 0, 0, 0,         1, 10, 32'hA0, 1, 1, 1, 1, 1);
        add(0, 1, 3, 32'h33, 0, 0, 0,         1, 3, 32'h33, 0, 0, 1, 0, 1);
        // fill, back-pressure, forced drain, ordering
        add(0, 1, 3, 32'h33, 1, 8, 32'h80,    1, 3, 32'h33, 0, 0, 1, 0, 1);
        add(0, 1, 3, 32'h33, 1, 9, 32'h90,    1, 3, 32'h33, 0, 0, 1, 1, 1);
        add(0, 1, 3, 32'h33, 1, 11, 32'hB0,   1, 3, 32'h33, 0, 0, 0, 2, 1);
        add(0, 1, 3, 32'h33, 1, 11, 32'hB0,   1, 3, 32'h33, 0, 0, 0, 2, 1);
        add(0, 1, 3, 32'h33, 1, 11, 32'hB0,   1, 8, 32'h80, 1, 1, 0, 2, 1);
        add(0, 1, 3, 32'h33, 1, 11, 32'hB0,   1, 3, 32'h33, 0, 0, 1, 1, 1);
        add(0, 0, 0, 0,      0, 0, 0,         1, 9, 32'h90, 1, 0, 0, 2, 1);
        add(0, 0, 0, 0,      0, 0, 0,         1, 11, 32'hB0, 1, 0, 1, 1, 1);
        add(0, 0, 0, 0,      0, 0, 0,         0, 0, 0, 0, 0, 1, 0, 1);
        // x0 writes from either side
        add(0, 1, 0, 32'h77, 1, 0, 32'hDEAD,  0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0,      0, 0, 0,         0, 0, 0, 0, 0, 1, 0, 1);
`ifdef WBARB_BYPASS_EN
        add(0, 0, 0, 0,      1, 12, 32'h55,   1, 12, 32'h55, 1, 0, 1, 0, 1);
        add(0, 0, 0, 0,      0, 0, 0,         0, 0, 0, 0, 0, 1, 0, 1);
`else
        add(0, 0, 0, 0,      1, 12, 32'h55,   0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0,      0, 0, 0,         1, 12, 32'h55, 1, 0, 1, 1, 1);
`endif
        add(0, 0, 0, 0,      0, 0, 0,         0, 0, 0, 0, 0, 1, 0, 1);
        // reset mid-operation discards the buffered result
        add(0, 1, 3, 32'h33, 1, 14, 32'hE0,   1, 3, 32'h33, 0, 0, 1, 0, 1);
        add(1, 1, 3, 32'h33, 0, 0, 0,         0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0,      0, 0, 0,         0, 0, 0, 0, 0, 1, 0, 1);
        // simultaneous push and pop
        add(0, 1, 3, 32'h33, 1, 15, 32'hF0,   1, 3, 32'h33, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0,      1, 16, 32'h100,  1, 15, 32'hF0, 1, 0, 1, 1, 1);
        add(0, 0, 0, 0,      0, 0, 0,         1, 16, 32'h100, 1, 0, 1, 1, 1);
        add(0, 0, 0, 0,      0, 0, 0,         0, 0, 0, 0, 0, 1, 0, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; RegWriteW = vecs[i].we; RdW = vecs[i].rd; ResultW = vecs[i].res;
            mdu_valid = vecs[i].mv; mdu_rd = vecs[i].mrd; mdu_data = vecs[i].md;
            #1;
            check("rf_we", i, 32'(rf_we), 32'(vecs[i].eWe));
            check("rf_rd", i, 32'(rf_rd), 32'(vecs[i].eRd));
            check("rf_wdata", i, rf_wdata, vecs[i].eData);
            check("grant_mdu", i, 32'(grant_mdu), 32'(vecs[i].eGnt));
            check("stall_req", i, 32'(stall_req), 32'(vecs[i].eStall));
            check("mdu_ready", i, 32'(mdu_ready), 32'(vecs[i].eRdy));
            if (vecs[i].chkPend) check("pending_cnt", i, 32'(pending_cnt), 32'(vecs[i].ePend));
        end

        // hand-written: count blocked cycles until the starvation guard fires
        begin
            int n;
            @(negedge clk);
            reset = 1'b0; RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h33;
            mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_data = 32'h2000;
            n = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                mdu_valid = 1'b0;
                #1;
                n++;
                if (stall_req) break;
            end
            check("starve_cycles", 100, 32'(n), 32'd4);
            check("starve_rd", 100, 32'(rf_rd), 32'd20);
            check("starve_data", 100, rf_wdata, 32'h2000);
            @(negedge clk);
            #1;
            check("stall_once", 101, 32'(stall_req), 32'd0);
            check("wb_resumes", 101, 32'(rf_rd), 32'd3);
            check("drained", 101, 32'(pending_cnt), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
